// File: rtl/lbdr_input_fifo_pkg.sv
//------------------------------------------------------------------------------
// lbdr_input_fifo_pkg
// Shared flit codes, header field offsets and write-side framing states used by
// the input buffer, LBDR and crossbar.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lbdr_input_fifo_pkg;

  // Flit type codes carried in the top three bits of every flit
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  // Field MSB positions, expressed as bit offsets below DATA_WIDTH-1
  localparam int FLIT_ID_MSB = 0;   // 3-bit flit_id
  localparam int SRC_MSB     = 3;   // 4-bit src_addr
  localparam int DST_MSB     = 7;   // 4-bit dst_addr

  // Packet framing as seen on the write side of the buffer
  typedef enum logic [0:0] {
    FR_IDLE   = 1'b0,
    FR_IN_PKT = 1'b1
  } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/lbdr_input_fifo_mem.sv
//------------------------------------------------------------------------------
// lbdr_input_fifo_mem
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read so
// the head entry falls straight through to the output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lbdr_input_fifo_mem
  import lbdr_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Storage is deliberately not reset; stale entries are masked by empty
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Capture the incoming flit into the slot addressed by the write pointer
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/lbdr_input_fifo.sv
//------------------------------------------------------------------------------
// lbdr_input_fifo
// Per-port FWFT input buffer ahead of LBDR. Credit return per read, sticky
// overflow flag and a write-side HEADER..TAIL framing monitor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lbdr_input_fifo
  import lbdr_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,          // asynchronous, active-low
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  credit_out,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  overflow_err,
  output logic                  proto_err
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam int             DEPTH_M1   = DEPTH - 1;
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] LAST_PTR = DEPTH_M1[PTR_W-1:0];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_credit;
  logic             r_overflow;
  logic             r_proto;
  frame_state_e     r_frame;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [2:0]       w_wr_id;

  // Status comes only from registered occupancy, never from this cycle's inputs
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_COUNT);
  assign w_wr_acc = valid_in && !w_full;
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_id  = data_in[DATA_WIDTH-1-FLIT_ID_MSB -: 3];

  lbdr_input_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_out)
  );

  // Pointer, occupancy and credit bookkeeping for accepted reads and writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
    end else begin
      r_credit <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: any write attempt against a full buffer is lost and flagged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (valid_in && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Framing monitor; only accepted writes advance it, bad flits are still stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame <= FR_IDLE;
      r_proto <= 1'b0;
    end else if (w_wr_acc) begin
      case (r_frame)
        FR_IDLE: begin
          if (w_wr_id == FLIT_HEADER) begin
            r_frame <= FR_IN_PKT;
          end else begin
            r_proto <= 1'b1;
          end
        end
        FR_IN_PKT: begin
          if (w_wr_id == FLIT_TAIL) begin
            r_frame <= FR_IDLE;
          end else if (w_wr_id != FLIT_BODY) begin
            r_proto <= 1'b1;
          end
        end
        default: begin
          r_frame <= FR_IDLE;
          r_proto <= 1'b1;
        end
      endcase
    end
  end

  assign empty        = w_empty;
  assign full         = w_full;
  assign credit_out   = r_credit;
  assign overflow_err = r_overflow;
  assign proto_err    = r_proto;
  assign flit_id      = data_out[DATA_WIDTH-1-FLIT_ID_MSB -: 3];
  assign dst_addr     = data_out[DATA_WIDTH-1-DST_MSB -: 4];

endmodule

`default_nettype wire

// File: tb/tb_lbdr_input_fifo.sv
//------------------------------------------------------------------------------
// tb_lbdr_input_fifo
// Directed scenarios plus randomized traffic, checked against a queue-based
// reference model of the input buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lbdr_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] BDY = 3'b010;
  localparam logic [2:0] TL  = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic          credit_out, empty, full, overflow_err, proto_err;
  logic [DW-1:0] data_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of held flits plus flag/packet state
  logic [DW-1:0] mq[$];
  bit m_in_pkt, m_ovf, m_perr, m_credit;

  lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .credit_out   (credit_out),
    .rd_en        (rd_en),
    .empty        (empty),
    .full         (full),
    .data_out     (data_out),
    .flit_id      (flit_id),
    .dst_addr     (dst_addr),
    .overflow_err (overflow_err),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mkflit(input logic [2:0] id, input logic [3:0] dst);
    logic [20:0] pay;
    pay = 21'($urandom);
    return {id, 4'h5, dst, pay};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_in_pkt = 0; m_ovf = 0; m_perr = 0; m_credit = 0;
  endtask

  // One clock edge of the buffer, described as queue operations and packet rules
  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit r);
    bit was_full, rd, wr;
    logic [2:0] id;
    was_full = (mq.size() == DEPTH);
    rd = r && (mq.size() > 0);
    wr = v && !was_full;
    m_credit = rd;
    if (v && was_full) m_ovf = 1;
    if (rd) void'(mq.pop_front());
    if (wr) begin
      mq.push_back(d);
      id = d[DW-1 -: 3];
      if (id == HDR) begin
        if (m_in_pkt) m_perr = 1; else m_in_pkt = 1;
      end else if (id == BDY) begin
        if (!m_in_pkt) m_perr = 1;
      end else if (id == TL) begin
        if (!m_in_pkt) m_perr = 1; else m_in_pkt = 0;
      end else begin
        m_perr = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [DW-1:0] head;
    check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
    check({tag, "_credit"}, 32'(credit_out), 32'(m_credit));
    check({tag, "_ovf"},  32'(overflow_err), 32'(m_ovf));
    check({tag, "_perr"}, 32'(proto_err), 32'(m_perr));
    if (mq.size() > 0) begin
      head = mq[0];
      check({tag, "_data"}, data_out, head);
      check({tag, "_fid"},  32'(flit_id), 32'(head[DW-1 -: 3]));
      check({tag, "_dst"},  32'(dst_addr), 32'(head[DW-8 -: 4]));
    end
  endtask

  task automatic step(input string tag, input bit v, input logic [DW-1:0] d, input bit r);
    valid_in = v; data_in = d; rd_en = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    compare_all(tag);
  endtask

  // Assert reset away from a clock edge and check it takes effect immediately
  task automatic do_reset(input string tag);
    valid_in = 0; rd_en = 0;
    rst = 1'b0;
    #1;
    model_clear();
    compare_all({tag, "_async"});
    @(posedge clk);
    #1;
    compare_all({tag, "_held"});
    rst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] f;
    logic [2:0]    rid;
    int            pick;

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all("por");
    rst = 1'b1;

    // Idle with rd_en held high: nothing to read, no credit
    for (int i = 0; i < 10; i++) step("idle", 0, '0, 1);

    // Short packet: header to dst A, body, tail; then drain
    step("pk_h", 1, mkflit(HDR, 4'hA), 0);
    check("pk_h_dstA", 32'(dst_addr), 32'h0000000A);
    step("pk_b", 1, mkflit(BDY, 4'h0), 0);
    step("pk_t", 1, mkflit(TL,  4'h0), 0);
    for (int i = 0; i < 3; i++) step("pk_rd", 0, '0, 1);
    step("pk_idle", 0, '0, 0);

    // Fill, overflow attempt, full with simultaneous read and write
    step("fl0", 1, mkflit(HDR, 4'h3), 0);
    for (int i = 0; i < 3; i++) step("fl", 1, mkflit(BDY, 4'h0), 0);
    step("ovf", 1, mkflit(BDY, 4'h1), 0);
    step("full_rw", 1, mkflit(BDY, 4'h2), 1);
    step("to_half", 0, '0, 1);
    // Steady half occupancy: pointers wrap while order must hold
    for (int i = 0; i < 8; i++) step("half_rw", 1, mkflit(BDY, 4'(i)), 1);
    for (int i = 0; i < 3; i++) step("half_drain", 0, '0, 1);

    // Framing: body first after reset, then a doubled header
    do_reset("r1");
    step("body_first", 1, mkflit(BDY, 4'h0), 0);
    do_reset("r2");
    step("hh0", 1, mkflit(HDR, 4'h1), 0);
    step("hh1", 1, mkflit(HDR, 4'h2), 0);

    // Reset in the middle of a packet, then a fresh header must be clean
    do_reset("r3");
    step("mid_h", 1, mkflit(HDR, 4'h7), 0);
    step("mid_b", 1, mkflit(BDY, 4'h0), 0);
    #2;
    do_reset("r_mid");
    step("post_h", 1, mkflit(HDR, 4'h9), 0);
    step("post_t", 1, mkflit(TL, 4'h0), 1);

    // Randomized traffic, mostly legal codes with occasional illegal ones
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rr");
      for (int i = 0; i < 150; i++) begin
        pick = int'($urandom_range(0, 15));
        if (pick < 4)       rid = HDR;
        else if (pick < 10) rid = BDY;
        else if (pick < 14) rid = TL;
        else                rid = 3'($urandom);
        f = mkflit(rid, 4'($urandom));
        step("rnd", ($urandom_range(0, 9) < 6), f, ($urandom_range(0, 1) == 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
